// File: rtl/fpu_pkg.sv
// Shared floating-point constants and types for the divider write-back path.
//   QNAN     : canonical quiet NaN returned for 0/0
//   EXP_INF  : all-ones exponent used to build a signed infinity
//   fdiv_res_t : corrected quotient plus its exception flags, as stored in the
//                write-back buffer
package fpu_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    typedef struct packed {
        logic [31:0] res;
        logic        dz;
        logic        nv;
    } fdiv_res_t;

endpackage

// File: rtl/fdiv_fixup.sv
// Combinational correction of the raw quotient from the float divider.
// Ports:
//   in_s  : raw quotient (sign bit is the XOR of operand signs)
//   in_ze : divisor magnitude is zero
//   in_az : dividend magnitude is zero
//   fix   : corrected result with dz/nv flags
module fdiv_fixup
    import fpu_pkg::*;
(
    input  logic [31:0] in_s,
    input  logic        in_ze,
    input  logic        in_az,
    output fdiv_res_t   fix
);

    always_comb begin
        fix.res = in_s;
        fix.dz  = 1'b0;
        fix.nv  = 1'b0;
        if (in_ze && in_az) begin
            // 0/0 has no meaningful sign: return the canonical quiet NaN.
            fix.res = QNAN;
            fix.nv  = 1'b1;
        end else if (in_ze) begin
            // x/0 keeps the quotient sign and becomes infinity.
            fix.res = {in_s[31], EXP_INF, 23'h0};
            fix.dz  = 1'b1;
        end else if (in_az) begin
            // 0/x is an exact signed zero regardless of what the divider produced.
            fix.res = {in_s[31], 31'h0};
        end
    end

endmodule

// File: rtl/fdiv_wb.sv
// Write-back stage for the float divider: corrects special cases, buffers
// results in a small circular FIFO and keeps sticky exception status.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : result handshake from the divider (in_ready = !full)
//   in_s, in_ze, in_az    : raw quotient and operand-zero indications
//   out_valid/out_ready   : result handshake to the consumer (out_valid = !empty)
//   out_res/out_dz/out_nv : head-of-buffer result and its flags
//   sticky_dz/sticky_nv   : accumulated exception status, cleared by sticky_clr
//   retired               : number of results consumed, modulo 256
module fdiv_wb
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_s,
    input  logic        in_ze,
    input  logic        in_az,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_dz,
    output logic        out_nv,
    output logic        sticky_dz,
    output logic        sticky_nv,
    input  logic        sticky_clr,
    output logic [7:0]  retired
);

    localparam int AW = $clog2(DEPTH);

    fdiv_res_t       fix;
    fdiv_res_t       mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      retired_q, retired_d;
    logic            sticky_dz_q, sticky_dz_d;
    logic            sticky_nv_q, sticky_nv_d;

    logic            full, empty, push, pop;

    fdiv_fixup u_fixup (
        .in_s  (in_s),
        .in_ze (in_ze),
        .in_az (in_az),
        .fix   (fix)
    );

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    // Readiness depends only on occupancy, so a same-cycle pop never frees a
    // slot for a push while full.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        retired_d   = retired_q;
        sticky_dz_d = sticky_dz_q;
        sticky_nv_d = sticky_nv_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            retired_d = retired_q + 8'd1;
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        // Clear first, then OR in new events so a set wins over a clear.
        if (sticky_clr) begin
            sticky_dz_d = 1'b0;
            sticky_nv_d = 1'b0;
        end
        if (push) begin
            sticky_dz_d = sticky_dz_d | fix.dz;
            sticky_nv_d = sticky_nv_d | fix.nv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            retired_q   <= '0;
            sticky_dz_q <= 1'b0;
            sticky_nv_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            retired_q   <= retired_d;
            sticky_dz_q <= sticky_dz_d;
            sticky_nv_q <= sticky_nv_d;
        end
    end

    // Result storage carries no reset; its contents are only observed through
    // out_valid, which is controlled by the reset occupancy.
    always_ff @(posedge clk) begin
        if (push && rst_n) mem_q[wr_ptr_q] <= fix;
    end

    assign out_res   = mem_q[rd_ptr_q].res;
    assign out_dz    = mem_q[rd_ptr_q].dz;
    assign out_nv    = mem_q[rd_ptr_q].nv;
    assign sticky_dz = sticky_dz_q;
    assign sticky_nv = sticky_nv_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fdiv_wb.sv
// Scoreboard bench for fdiv_wb: the stimulus process pushes expected results
// into a queue as they are accepted, the monitor process compares every cycle
// and pops on each consumed result.
module tb_fdiv_wb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_s = '0;
    logic        in_ze = 1'b0;
    logic        in_az = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic        out_dz;
    logic        out_nv;
    logic        sticky_dz;
    logic        sticky_nv;
    logic        sticky_clr = 1'b0;
    logic [7:0]  retired;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [33:0] exp_q[$];
    logic [7:0]  exp_retired = 8'd0;
    logic        exp_sdz = 1'b0;
    logic        exp_snv = 1'b0;
    int          occ_pre = 0;

    always #5 clk = ~clk;

    fdiv_wb #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_ze      (in_ze),
        .in_az      (in_az),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_dz     (out_dz),
        .out_nv     (out_nv),
        .sticky_dz  (sticky_dz),
        .sticky_nv  (sticky_nv),
        .sticky_clr (sticky_clr),
        .retired    (retired)
    );

    // Expected {res, dz, nv} from the IEEE special-case rules for division.
    function automatic logic [33:0] ref_div(input logic [31:0] s, input logic ze, input logic az);
        if (ze && az) return {32'h7FC00000, 1'b0, 1'b1};
        if (ze)       return {s[31], 8'hFF, 23'h0, 1'b1, 1'b0};
        if (az)       return {s[31], 31'h0, 1'b0, 1'b0};
        return {s, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares at the falling edge, consumes a queue entry for every
    // pop that the next rising edge will perform.
    initial begin
        forever begin
            @(negedge clk);
            occ_pre = exp_q.size();
            chk("in_ready",  {31'h0, in_ready},  {31'h0, occ_pre < DEPTH});
            chk("out_valid", {31'h0, out_valid}, {31'h0, occ_pre != 0});
            chk("retired",   {24'h0, retired},   {24'h0, exp_retired});
            chk("sticky_dz", {31'h0, sticky_dz}, {31'h0, exp_sdz});
            chk("sticky_nv", {31'h0, sticky_nv}, {31'h0, exp_snv});
            if (occ_pre != 0) begin
                chk("out_res", out_res, exp_q[0][33:2]);
                chk("out_dz",  {31'h0, out_dz}, {31'h0, exp_q[0][1]});
                chk("out_nv",  {31'h0, out_nv}, {31'h0, exp_q[0][0]});
                if (rst_n && out_ready) begin
                    void'(exp_q.pop_front());
                    exp_retired = exp_retired + 8'd1;
                end
            end
        end
    end

    // One clock of stimulus; the reference model is updated after the
    // monitor has sampled, ahead of the edge that commits these inputs.
    task automatic step(input logic v, input logic [31:0] s, input logic ze, input logic az,
                        input logic ordy, input logic clr, input logic rstn);
        logic acc;
        logic [33:0] e;
        @(posedge clk);
        #1;
        rst_n      = rstn;
        in_valid   = v;
        in_s       = s;
        in_ze      = ze;
        in_az      = az;
        out_ready  = ordy;
        sticky_clr = clr;
        @(negedge clk);
        #1;
        if (!rstn) begin
            exp_q.delete();
            exp_retired = 8'd0;
            exp_sdz = 1'b0;
            exp_snv = 1'b0;
        end else begin
            acc = v && (occ_pre < DEPTH);
            e = ref_div(s, ze, az);
            if (clr) begin
                exp_sdz = 1'b0;
                exp_snv = 1'b0;
            end
            if (acc) begin
                exp_sdz = exp_sdz | e[1];
                exp_snv = exp_snv | e[0];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 1'b0, 1'b0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Normal quotient passes through, one pop.
        step(1, 32'h40000000, 0, 0, 1, 0, 1);
        idle(1);
        idle(1);

        // Divide by zero sets sticky_dz until cleared.
        step(1, 32'hC1234567, 1, 0, 0, 0, 1);
        idle(0);
        idle(1);
        idle(1);
        step(0, 0, 0, 0, 1, 1, 1);
        idle(1);

        // 0/0 gives QNaN; a clear in the same cycle as an nv accept loses.
        step(1, 32'h80000000, 1, 1, 1, 0, 1);
        idle(1);
        step(1, 32'h12345678, 1, 1, 1, 1, 1);
        idle(1);
        step(1, 32'h81234567, 0, 1, 1, 1, 1);
        idle(1);

        // Back-pressure: third push is held until the consumer drains.
        step(1, 32'h3F800000, 0, 0, 0, 0, 1);
        step(1, 32'h40400000, 0, 0, 0, 0, 1);
        step(1, 32'h40800000, 0, 0, 0, 0, 1);
        step(1, 32'h40800000, 0, 0, 0, 0, 1);
        step(1, 32'h40800000, 0, 0, 1, 0, 1);
        step(1, 32'h40A00000, 0, 0, 1, 0, 1);
        idle(1);
        idle(1);
        idle(1);

        // Enough consumed results to wrap the retired counter.
        for (int i = 0; i < 300; i++) step(1, $urandom, 0, 0, 1, 0, 1);
        idle(1);
        idle(1);

        // Reset with two buffered results.
        step(1, 32'h11111111, 0, 0, 0, 0, 1);
        step(1, 32'h22222222, 0, 0, 0, 0, 1);
        step(1, 32'h33333333, 0, 0, 0, 0, 0);
        idle(1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
